// File: rtl/line_fifo_ctrl.sv
// Line-buffer FIFO controller: tracks which line RAM is being written, which
// two banks feed the interpolator, and how many lines are buffered.
// Optional dropped-line statistic enabled by macro LFC_DROP_STAT_EN.
module line_fifo_ctrl #(
  parameter int unsigned BUFFER_SIZE       = 4,
  parameter int unsigned BUFFER_SIZE_WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wrFrameStart,
  input  logic                         wrLineDone,
  input  logic                         jmp1,
  input  logic                         jmp2,
  output logic [BUFFER_SIZE_WIDTH-1:0] wrBank,
  output logic [BUFFER_SIZE_WIDTH-1:0] rdBank0,
  output logic [BUFFER_SIZE_WIDTH-1:0] rdBank1,
  output logic [BUFFER_SIZE_WIDTH:0]   fifoNum,
  output logic                         calRdy,
  output logic                         ovf,
  output logic [7:0]                   dropCnt
);

  localparam int unsigned PW = BUFFER_SIZE_WIDTH;
  localparam int unsigned CW = BUFFER_SIZE_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   rd_bank1_q, rd_bank1_d;
  logic [CW-1:0]   count_q, count_d;
  logic            cal_rdy_q, cal_rdy_d;
  logic            ovf_q, ovf_d;
  logic            drop_c;

  // Pointer add that wraps modulo BUFFER_SIZE, valid for non-power-of-two sizes.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] inc);
    logic [PW:0] sum;
    sum = {1'b0, p} + (PW+1)'(inc);
    if (sum >= (PW+1)'(BUFFER_SIZE)) begin
      sum = sum - (PW+1)'(BUFFER_SIZE);
    end
    return PW'(sum);
  endfunction

  // Pointer / occupancy update: frame start clears, IDLE ignores line events.
  always_comb begin
    logic          active;
    logic          wr_req;
    logic          wr_ok;
    logic [CW-1:0] req_n;
    logic [CW-1:0] rel;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    drop_c   = 1'b0;

    active = (state_q != ST_IDLE) && !wrFrameStart;
    wr_req = active && wrLineDone;
    wr_ok  = wr_req && (count_q != CW'(BUFFER_SIZE));
    drop_c = wr_req && (count_q == CW'(BUFFER_SIZE));

    if (!active)   req_n = '0;
    else if (jmp2) req_n = CW'(2);
    else if (jmp1) req_n = CW'(1);
    else           req_n = '0;

    rel = (req_n > count_q) ? count_q : req_n;

    if (wrFrameStart) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = ptr_add(wr_ptr_q, {1'b0, wr_ok});
      rd_ptr_d = ptr_add(rd_ptr_q, 2'(rel));
      count_d  = count_q + CW'(wr_ok) - rel;
    end

    if (drop_c) ovf_d = 1'b1;
    rd_bank1_d = ptr_add(rd_ptr_d, 2'd1);
  end

  // Next-state logic: frame start always re-enters FILL; RUN needs two lines.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (wrFrameStart) state_d = ST_FILL;
      ST_FILL: begin
        if (wrFrameStart)                state_d = ST_FILL;
        else if (count_d >= CW'(2))      state_d = ST_RUN;
      end
      ST_RUN: begin
        if (wrFrameStart || count_d < CW'(2)) state_d = ST_FILL;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: ready flag follows the state being entered.
  always_comb begin
    cal_rdy_d = (state_d == ST_RUN);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_bank1_q <= PW'(1);
      count_q    <= '0;
      cal_rdy_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_bank1_q <= rd_bank1_d;
      count_q    <= count_d;
      cal_rdy_q  <= cal_rdy_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef LFC_DROP_STAT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of dropped lines; only reset clears it.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_c && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  // Drop statistic register.
  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign dropCnt = drop_cnt_q;
`else
  assign dropCnt = 8'd0;
`endif

  assign wrBank  = wr_ptr_q;
  assign rdBank0 = rd_ptr_q;
  assign rdBank1 = rd_bank1_q;
  assign fifoNum = count_q;
  assign calRdy  = cal_rdy_q;
  assign ovf     = ovf_q;

endmodule

// File: doc/line_fifo_ctrl.md
LINE_FIFO_CTRL -- requirements
Module: line_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter BUFFER_SIZE, default 4, meaning the number of line RAMs in the FIFO (legal range 2..16).
REQ-002 The block SHALL have parameter BUFFER_SIZE_WIDTH, default 2, meaning the bank index width, derived as 1/2/3/4 for BUFFER_SIZE <=2/<=4/<=8/<=16.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  the single clock; all state changes occur on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 wrFrameStart  in  1  one-cycle pulse from the input side at the start of an input frame.
REQ-007 wrLineDone  in  1  one-cycle pulse when a full input line has been written to bank wrBank.
REQ-008 jmp1  in  1  pulse from the interpolator requesting the release of 1 line.
REQ-009 jmp2  in  1  pulse from the interpolator requesting the release of 2 lines.
REQ-010 wrBank  out  BUFFER_SIZE_WIDTH  bank currently being written.
REQ-011 rdBank0  out  BUFFER_SIZE_WIDTH  upper interpolation row bank.
REQ-012 rdBank1  out  BUFFER_SIZE_WIDTH  lower interpolation row bank.
REQ-013 fifoNum  out  BUFFER_SIZE_WIDTH+1  count of lines written and not yet released.
REQ-014 calRdy  out  1  high when the FIFO is in RUN.
REQ-015 ovf  out  1  sticky flag, set when a line was dropped because the FIFO was full.
REQ-016 dropCnt  out  8  dropped-line statistic (see Configuration).

Function
REQ-017 All outputs SHALL be registered and SHALL reflect an input event exactly 1 cycle after it is sampled.
REQ-018 wrPtr, rdPtr and count SHALL be internal registers, with wrBank=wrPtr, rdBank0=rdPtr, rdBank1=(rdPtr+1) mod BUFFER_SIZE, and fifoNum=count.
REQ-019 All pointer arithmetic SHALL wrap modulo BUFFER_SIZE, including when BUFFER_SIZE is not a power of two.
REQ-020 On wrLineDone with count<BUFFER_SIZE, wrPtr SHALL advance by 1 and count SHALL increment by 1.
REQ-021 On wrLineDone with count==BUFFER_SIZE (full), the line SHALL be dropped: wrPtr and count unchanged, ovf set to 1.
REQ-022 The release amount n SHALL be 2 when jmp2 is high, else 1 when jmp1 is high, else 0; jmp2 wins if both are high.
REQ-023 The applied release SHALL be min(n, count), with rdPtr advancing and count decreasing by the applied release (no underflow).
REQ-024 When a write and a release occur in the same cycle, count SHALL become count+1-release, evaluated against the pre-cycle count (full check uses the pre-cycle count).
REQ-025 On wrFrameStart, wrPtr, rdPtr and count SHALL be cleared to 0 and state SHALL go to FILL; a same-cycle wrLineDone or jmp SHALL be ignored; ovf SHALL NOT be cleared.
REQ-026 The FSM SHALL have states IDLE, FILL and RUN.
REQ-027 In IDLE, wrLineDone and jmp SHALL be ignored, and the only exit SHALL be wrFrameStart to FILL.
REQ-028 FILL SHALL go to RUN when the next count >= 2.
REQ-029 RUN SHALL go to FILL when the next count < 2.
REQ-030 calRdy SHALL equal 1 exactly when the registered state is RUN.

Reset
REQ-031 When rst is high at a clock edge, state SHALL go to IDLE, and wrPtr, rdPtr, count, wrBank, rdBank0, fifoNum, calRdy, ovf and dropCnt SHALL all become 0, with rdBank1=1.
REQ-032 rst SHALL take priority over every other input, including mid-frame and mid-release.

Configuration
REQ-033 Macro LFC_DROP_STAT_EN SHALL control the dropped-line statistic.
REQ-034 With LFC_DROP_STAT_EN defined, dropCnt SHALL increment on each dropped line, saturate at 255, and be cleared only by rst.
REQ-035 Without LFC_DROP_STAT_EN, dropCnt SHALL be tied to 0 and no counter logic SHALL be synthesized; all other behaviour SHALL be identical.

Verification
REQ-036 The bench SHALL cover: rst, then wrFrameStart, then 2 wrLineDone -> fifoNum=2, wrBank=2, calRdy=1 one cycle after the second pulse.
REQ-037 The bench SHALL cover: 5 wrLineDone with BUFFER_SIZE=4 -> fifoNum=4, wrBank=0, ovf=1, and dropCnt=1 when LFC_DROP_STAT_EN is defined (0 otherwise).
REQ-038 The bench SHALL cover: count=1, then jmp2 -> fifoNum=0, rdPtr advanced by 1, calRdy=0.
REQ-039 The bench SHALL cover: count=4 (full), then wrLineDone together with jmp1 -> line dropped, fifoNum=3, ovf=1.
REQ-040 The bench SHALL cover: rdPtr=3 with BUFFER_SIZE=4 -> rdBank0=3, rdBank1=0; after jmp1, rdBank0=0, rdBank1=1.
REQ-041 The bench SHALL cover: wrFrameStart with count=3 and a same-cycle jmp1 -> count=0, pointers=0, state FILL, ovf unchanged.
